// File: rtl/simt_stack_bank_pkg.sv
// ============================================================================
// Module  : simt_stack_bank_pkg
// Brief   : Shared types and defaults for the SIMT divergence stack bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package simt_stack_bank_pkg;

  localparam int SIMT_BANK_WARPS = 8;
  localparam int SIMT_WARP_SIZE  = 32;
  localparam int SIMT_PC_W       = 32;

  localparam logic [SIMT_PC_W-1:0] SIMT_RPC_NONE = '1;

  typedef enum logic [1:0] {
    SIMT_OP_BRANCH    = 2'd0,
    SIMT_OP_RECONV    = 2'd1,
    SIMT_OP_WARP_INIT = 2'd2,
    SIMT_OP_RSVD      = 2'd3
  } simt_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUSH2 = 2'd1,
    ST_RESP  = 2'd2
  } simt_state_e;

  typedef struct packed {
    logic [SIMT_PC_W-1:0]      next_pc;
    logic [SIMT_WARP_SIZE-1:0] mask;
    logic [SIMT_PC_W-1:0]      rpc;
  } simt_bank_entry_t;

endpackage

`default_nettype wire

// File: rtl/simt_stack_bank_mem.sv
// ============================================================================
// Module  : simt_stack_bank_mem
// Brief   : NUM_WARPS*DEPTH entry array, one write port, combinational read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module simt_stack_bank_mem
  import simt_stack_bank_pkg::*;
#(
  parameter int NUM_WARPS = SIMT_BANK_WARPS,
  parameter int DEPTH     = 16,
  parameter int ENTRY_W   = 96,
  parameter int ADDR_W    = $clog2(NUM_WARPS * DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] r_mem [NUM_WARPS*DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/simt_stack_bank.sv
// ============================================================================
// Module  : simt_stack_bank
// Brief   : Multi-warp SIMT reconvergence stack bank with branch split logic.
//           Optional statistics outputs enabled by SIMT_STACK_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module simt_stack_bank
  import simt_stack_bank_pkg::*;
#(
  parameter int NUM_WARPS = SIMT_BANK_WARPS,
  parameter int DEPTH     = 16,
  parameter int WARP_SIZE = SIMT_WARP_SIZE,
  parameter int PC_W      = SIMT_PC_W,
  parameter int WID_W     = $clog2(NUM_WARPS),
  parameter int SP_W      = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [1:0]                op_type,
  input  logic [WID_W-1:0]          op_warp_id,
  input  logic [WARP_SIZE-1:0]      op_taken_mask,
  input  logic [PC_W-1:0]           op_target_pc,
  input  logic [PC_W-1:0]           op_fall_pc,
  input  logic [PC_W-1:0]           op_reconv_pc,
  output logic                      resp_valid,
  output logic [WID_W-1:0]          resp_warp_id,
  output logic [PC_W-1:0]           resp_pc,
  output logic [WARP_SIZE-1:0]      resp_mask,
  output logic [PC_W-1:0]           resp_rpc,
  output logic                      resp_err,
`ifdef SIMT_STACK_STATS_EN
  output logic [31:0]               stat_divergences,
  output logic [15:0]               stat_overflows,
  output logic [SP_W-1:0]           stat_max_depth,
`endif
  output logic [NUM_WARPS*SP_W-1:0] warp_depth
);

  localparam int SLOT_W = $clog2(DEPTH);
  localparam logic [SP_W-1:0] c_sp_limit = SP_W'(DEPTH - 2);

  typedef struct packed {
    logic [PC_W-1:0]      next_pc;
    logic [WARP_SIZE-1:0] mask;
    logic [PC_W-1:0]      rpc;
  } bank_entry_t;

  simt_state_e r_state, w_next;

  logic [SP_W-1:0]      r_sp       [NUM_WARPS];
  logic [WARP_SIZE-1:0] r_cur_mask [NUM_WARPS];
  logic [PC_W-1:0]      r_cur_rpc  [NUM_WARPS];

  logic [WID_W-1:0]     r_warp;
  logic [WARP_SIZE-1:0] r_t, r_n;
  logic [PC_W-1:0]      r_fall, r_reconv;

  logic [WID_W-1:0]     r_resp_warp;
  logic [PC_W-1:0]      r_resp_pc, r_resp_rpc;
  logic [WARP_SIZE-1:0] r_resp_mask;
  logic                 r_resp_err;

  simt_op_e             w_op;
  logic                 w_accept, w_div, w_ovf, w_we;
  logic [SP_W-1:0]      w_sp_cur, w_sp_m1;
  logic [WARP_SIZE-1:0] w_a, w_t, w_n;
  logic [PC_W-1:0]      w_rpc;
  logic [WID_W+SLOT_W-1:0] w_waddr, w_raddr;
  bank_entry_t          w_wdata, w_top;

  assign op_ready = (r_state == ST_IDLE);
  assign w_accept = op_valid && op_ready;
  assign w_op     = simt_op_e'(op_type);
  assign w_sp_cur = r_sp[op_warp_id];
  assign w_sp_m1  = w_sp_cur - 1'b1;
  assign w_a      = r_cur_mask[op_warp_id];
  assign w_rpc    = r_cur_rpc[op_warp_id];
  assign w_t      = op_taken_mask & w_a;
  assign w_n      = w_a & ~w_t;
  assign w_div    = (w_op == SIMT_OP_BRANCH) && (w_t != '0) && (w_n != '0);
  assign w_ovf    = (w_sp_cur > c_sp_limit);
  assign w_raddr  = {op_warp_id, w_sp_m1[SLOT_W-1:0]};

  simt_stack_bank_mem #(
    .NUM_WARPS (NUM_WARPS),
    .DEPTH     (DEPTH),
    .ENTRY_W   ($bits(bank_entry_t)),
    .ADDR_W    (WID_W + SLOT_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr (w_raddr),
    .rdata (w_top)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // A divergent branch writes the merge entry on acceptance, the fall-through entry in PUSH2.
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = ST_RESP;
          if (w_div && !w_ovf) begin
            w_next          = ST_PUSH2;
            w_we            = 1'b1;
            w_waddr         = {op_warp_id, w_sp_cur[SLOT_W-1:0]};
            w_wdata.next_pc = op_reconv_pc;
            w_wdata.mask    = w_a;
            w_wdata.rpc     = w_rpc;
          end
        end
      end
      ST_PUSH2: begin
        w_next          = ST_RESP;
        w_we            = 1'b1;
        w_waddr         = {r_warp, r_sp[r_warp][SLOT_W-1:0]};
        w_wdata.next_pc = r_fall;
        w_wdata.mask    = r_n;
        w_wdata.rpc     = r_reconv;
      end
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_sp[w]       <= '0;
        r_cur_mask[w] <= '1;
        r_cur_rpc[w]  <= '1;
      end
      r_warp      <= '0;
      r_t         <= '0;
      r_n         <= '0;
      r_fall      <= '0;
      r_reconv    <= '0;
      r_resp_warp <= '0;
      r_resp_pc   <= '0;
      r_resp_rpc  <= '0;
      r_resp_mask <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_warp      <= op_warp_id;
            r_t         <= w_t;
            r_n         <= w_n;
            r_fall      <= op_fall_pc;
            r_reconv    <= op_reconv_pc;
            r_resp_warp <= op_warp_id;
            r_resp_pc   <= op_target_pc;
            r_resp_mask <= w_a;
            r_resp_rpc  <= w_rpc;
            r_resp_err  <= 1'b0;
            case (w_op)
              SIMT_OP_BRANCH: begin
                if (w_n == '0) begin
                  r_resp_pc <= op_target_pc;
                end else if (w_t == '0) begin
                  r_resp_pc <= op_fall_pc;
                end else if (w_ovf) begin
                  r_resp_err <= 1'b1;
                  r_resp_pc  <= op_fall_pc;
                end else begin
                  r_sp[op_warp_id] <= w_sp_cur + 1'b1;
                end
              end
              SIMT_OP_RECONV: begin
                if (w_sp_cur == '0) begin
                  r_resp_err <= 1'b1;
                end else begin
                  r_sp[op_warp_id]       <= w_sp_m1;
                  r_cur_mask[op_warp_id] <= w_top.mask;
                  r_cur_rpc[op_warp_id]  <= w_top.rpc;
                  r_resp_pc              <= w_top.next_pc;
                  r_resp_mask            <= w_top.mask;
                  r_resp_rpc             <= w_top.rpc;
                end
              end
              SIMT_OP_WARP_INIT: begin
                r_sp[op_warp_id]       <= '0;
                r_cur_mask[op_warp_id] <= '1;
                r_cur_rpc[op_warp_id]  <= '1;
                r_resp_mask            <= '1;
                r_resp_rpc             <= '1;
              end
              default: r_resp_err <= 1'b1;
            endcase
          end
        end
        ST_PUSH2: begin
          r_sp[r_warp]       <= r_sp[r_warp] + 1'b1;
          r_cur_mask[r_warp] <= r_t;
          r_cur_rpc[r_warp]  <= r_reconv;
          r_resp_mask        <= r_t;
          r_resp_rpc         <= r_reconv;
        end
        default: begin
          r_resp_warp <= '0;
          r_resp_pc   <= '0;
          r_resp_rpc  <= '0;
          r_resp_mask <= '0;
          r_resp_err  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid   = (r_state == ST_RESP);
  assign resp_warp_id = r_resp_warp;
  assign resp_pc      = r_resp_pc;
  assign resp_mask    = r_resp_mask;
  assign resp_rpc     = r_resp_rpc;
  assign resp_err     = r_resp_err;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_depth
    assign warp_depth[g*SP_W +: SP_W] = r_sp[g];
  end

`ifdef SIMT_STACK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_divergences <= '0;
      stat_overflows   <= '0;
      stat_max_depth   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_accept && w_div) begin
        if (w_ovf) begin
          if (stat_overflows != '1) stat_overflows <= stat_overflows + 1'b1;
        end else begin
          if (stat_divergences != '1) stat_divergences <= stat_divergences + 1'b1;
        end
      end
      // The second push always produces the deepest pointer of a divergence.
      if (r_state == ST_PUSH2 && (r_sp[r_warp] + 1'b1) > stat_max_depth)
        stat_max_depth <= r_sp[r_warp] + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_simt_stack_bank.sv
// ============================================================================
// Module  : tb_simt_stack_bank
// Brief   : Directed and randomized checks of simt_stack_bank against a
//           stack-of-entries reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simt_stack_bank;

  localparam int NW = 8;
  localparam int DP = 16;
  localparam int SPW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            op_valid = 1'b0;
  logic            op_ready;
  logic [1:0]      op_type = '0;
  logic [2:0]      op_warp_id = '0;
  logic [31:0]     op_taken_mask = '0, op_target_pc = '0, op_fall_pc = '0, op_reconv_pc = '0;
  logic            resp_valid, resp_err;
  logic [2:0]      resp_warp_id;
  logic [31:0]     resp_pc, resp_mask, resp_rpc;
  logic [NW*SPW-1:0] warp_depth;
`ifdef SIMT_STACK_STATS_EN
  logic [31:0]     stat_divergences;
  logic [15:0]     stat_overflows;
  logic [SPW-1:0]  stat_max_depth;
`endif

  simt_stack_bank #(.NUM_WARPS(NW), .DEPTH(DP), .WARP_SIZE(32), .PC_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_type       (op_type),
    .op_warp_id    (op_warp_id),
    .op_taken_mask (op_taken_mask),
    .op_target_pc  (op_target_pc),
    .op_fall_pc    (op_fall_pc),
    .op_reconv_pc  (op_reconv_pc),
    .resp_valid    (resp_valid),
    .resp_warp_id  (resp_warp_id),
    .resp_pc       (resp_pc),
    .resp_mask     (resp_mask),
    .resp_rpc      (resp_rpc),
    .resp_err      (resp_err),
`ifdef SIMT_STACK_STATS_EN
    .stat_divergences (stat_divergences),
    .stat_overflows   (stat_overflows),
    .stat_max_depth   (stat_max_depth),
`endif
    .warp_depth    (warp_depth)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: each warp owns a plain array stack plus its live mask/rpc.
  logic [31:0] m_pc   [NW][DP];
  logic [31:0] m_msk  [NW][DP];
  logic [31:0] m_rp   [NW][DP];
  int          m_sp   [NW];
  logic [31:0] m_mask [NW];
  logic [31:0] m_rpc  [NW];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) begin
      m_sp[w] = 0;
      m_mask[w] = '1;
      m_rpc[w] = '1;
    end
  endfunction

  function automatic logic [NW*SPW-1:0] model_depths();
    logic [NW*SPW-1:0] v;
    v = '0;
    for (int w = 0; w < NW; w++) v[w*SPW +: SPW] = SPW'(m_sp[w]);
    return v;
  endfunction

  function automatic void model_push(input int w, input logic [31:0] pc, msk, rp);
    m_pc[w][m_sp[w]]  = pc;
    m_msk[w][m_sp[w]] = msk;
    m_rp[w][m_sp[w]]  = rp;
    m_sp[w]++;
  endfunction

  task automatic issue(input logic [1:0] t, input int w, input logic [31:0] tk,
                       input logic [31:0] tgt, input logic [31:0] fall, input logic [31:0] rc);
    logic [31:0] a, tm, nm, e_pc, e_mask, e_rpc;
    bit e_err, pc_care, got;
    int e_lat, lat, waited;
    a = m_mask[w];
    e_lat = 1; e_err = 0; pc_care = 1;
    e_pc = tgt; e_mask = a; e_rpc = m_rpc[w];
    case (t)
      2'd0: begin
        tm = tk & a;
        nm = a & ~tm;
        if (nm == 0) e_pc = tgt;
        else if (tm == 0) e_pc = fall;
        else if (DP - m_sp[w] < 2) begin e_err = 1; e_pc = fall; end
        else begin
          model_push(w, rc, a, m_rpc[w]);
          model_push(w, fall, nm, rc);
          m_mask[w] = tm; m_rpc[w] = rc;
          e_mask = tm; e_rpc = rc; e_lat = 2;
        end
      end
      2'd1: begin
        if (m_sp[w] == 0) begin e_err = 1; pc_care = 0; end
        else begin
          m_sp[w]--;
          e_pc = m_pc[w][m_sp[w]];
          m_mask[w] = m_msk[w][m_sp[w]];
          m_rpc[w] = m_rp[w][m_sp[w]];
          e_mask = m_mask[w]; e_rpc = m_rpc[w];
        end
      end
      2'd2: begin
        m_sp[w] = 0; m_mask[w] = '1; m_rpc[w] = '1;
        e_mask = '1; e_rpc = '1;
      end
      default: begin e_err = 1; pc_care = 0; end
    endcase

    @(negedge clk);
    op_valid = 1'b1; op_type = t; op_warp_id = 3'(w);
    op_taken_mask = tk; op_target_pc = tgt; op_fall_pc = fall; op_reconv_pc = rc;
    waited = 0;
    while (!op_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!op_ready) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    got = 0; lat = 0;
    for (int i = 1; i <= 4; i++) begin
      if (resp_valid) begin got = 1; lat = i; break; end
      if (i == 1) check("ready_in_push2", 64'(op_ready), 0);
      @(posedge clk); #1;
    end
    if (!got) check("resp_timeout", 0, 1);
    else begin
      check("latency", 64'(lat), 64'(e_lat));
      check("err", 64'(resp_err), 64'(e_err));
      check("warp_id", 64'(resp_warp_id), 64'(w));
      check("mask", 64'(resp_mask), 64'(e_mask));
      check("rpc", 64'(resp_rpc), 64'(e_rpc));
      if (pc_care) check("pc", 64'(resp_pc), 64'(e_pc));
      check("depths", 64'(warp_depth), 64'(model_depths()));
    end
  endtask

  function automatic logic [31:0] low_bit(input logic [31:0] m);
    return m & (~m + 32'd1);
  endfunction

  initial begin
    logic [31:0] tk;
    int w, sel;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(op_ready), 1);
    check("rst_valid", 64'(resp_valid), 0);
    check("rst_pc", 64'(resp_pc), 0);
    check("rst_depth", 64'(warp_depth), 0);
    @(negedge clk); rst = 1'b0;

    issue(2'd2, 0, 0, 32'h100, 0, 0);
    issue(2'd0, 0, 32'hFFFF_FFFF, 32'h200, 32'h180, 32'h300);
    issue(2'd0, 0, 32'h0000_FFFF, 32'h200, 32'h180, 32'h300);
    issue(2'd1, 0, 0, 0, 0, 0);
    issue(2'd1, 0, 0, 0, 0, 0);
    issue(2'd0, 0, 32'h0, 32'h240, 32'h244, 32'h300);

    // Bring w3 to DEPTH-1 with nested divergence, then one more split must overflow.
    issue(2'd2, 3, 0, 32'h400, 0, 0);
    issue(2'd0, 3, low_bit(m_mask[3]), 32'h410, 32'h414, 32'h4F0);
    issue(2'd1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      issue(2'd0, 3, m_mask[3] & (m_mask[3] - 1), 32'h420 + 32'(i), 32'h500 + 32'(i), 32'h600 + 32'(i));
    check("w3_depth", 64'(warp_depth[3*SPW +: SPW]), 64'(DP - 1));
    issue(2'd0, 3, m_mask[3] & (m_mask[3] - 1), 32'h700, 32'h704, 32'h708);
    issue(2'd1, 5, 0, 0, 0, 0);
    issue(2'd3, 6, 0, 32'h50, 0, 0);

    issue(2'd0, 2, 32'hFF00_FF00, 32'h800, 32'h804, 32'h900);
    issue(2'd0, 2, m_mask[2] & (m_mask[2] - 1), 32'h810, 32'h814, 32'h910);
    issue(2'd0, 1, 32'h1234_5678, 32'hA00, 32'hA04, 32'hB00);
    issue(2'd0, 2, 32'hFFFF_FFFF, 32'hC00, 32'hC04, 32'hC08);

    for (int i = 0; i < 200; i++) begin
      w = int'($urandom_range(0, NW - 1));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: tk = '1;
        1: tk = '0;
        2: tk = $urandom;
        default: tk = m_mask[w] & (m_mask[w] - 1);
      endcase
      sel = int'($urandom_range(0, 19));
      issue(sel < 10 ? 2'd0 : sel < 17 ? 2'd1 : sel < 19 ? 2'd2 : 2'd3, w, tk,
            $urandom, $urandom, $urandom);
    end

    // Reset during PUSH2 must suppress the response and clear every warp.
    issue(2'd2, 4, 0, 32'h10, 0, 0);
    @(negedge clk);
    op_valid = 1'b1; op_type = 2'd0; op_warp_id = 3'd4;
    op_taken_mask = 32'h0F0F_0F0F; op_target_pc = 32'h20; op_fall_pc = 32'h24; op_reconv_pc = 32'h28;
    while (!op_ready) @(negedge clk);
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("push2_ready", 64'(op_ready), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", 64'(resp_valid), 0);
    check("abort_depth", 64'(warp_depth), 0);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("abort_valid2", 64'(resp_valid), 0);
    issue(2'd1, 4, 0, 0, 0, 0);
    issue(2'd0, 4, 32'h0000_00FF, 32'h30, 32'h34, 32'h38);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
